// File: rtl/snake_move_scheduler.sv
// Move pacing and direction arbitration for the snake datapath.
// Optional feature: define PAUSE_EN to add the Pause input and the paused flag.
module snake_move_scheduler #(
    parameter int unsigned TICK_BASE = 12500000,
    parameter int unsigned TICK_STEP = 500000,
    parameter int unsigned TICK_MIN  = 2500000,
    parameter int unsigned LVL_MAX   = 15
) (
    input  logic       Clk_50mhz,
    input  logic       Rst,
    input  logic [2:0] Game_status,
    input  logic       Key_left,
    input  logic       Key_right,
    input  logic       Key_up,
    input  logic       Key_down,
    input  logic       Body_add_sig,
`ifdef PAUSE_EN
    input  logic       Pause,
`endif
    output logic       Move_tick,
    output logic [1:0] Dir,
    output logic [3:0] Speed_level,
    output logic       Key_drop
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t      state;
    logic [31:0] counter;
    logic [31:0] period;
    logic [1:0]  q_slot0;
    logic [1:0]  q_slot1;
    logic [1:0]  q_count;
    logic        paused;

    logic [31:0] step_total;
    logic [31:0] reload_period;
    logic        run_now;
    logic        entry;
    logic        run_active;
    logic        tick_now;
    logic        pop;
    logic        key_valid;
    logic [1:0]  cand;
    logic [1:0]  ref_dir;
    logic        accept;

`ifdef PAUSE_EN
    always_ff @(posedge Clk_50mhz or posedge Rst) begin
        if (Rst)
            paused <= 1'b0;
        else if (Game_status != 3'b010)
            paused <= 1'b0;
        else if (Pause)
            paused <= ~paused;
    end
`else
    assign paused = 1'b0;
`endif

    // Clamp is evaluated before subtracting so the period never wraps.
    always_comb begin
        step_total = {28'd0, Speed_level} * TICK_STEP;
        if (step_total >= TICK_BASE || (TICK_BASE - step_total) < TICK_MIN)
            reload_period = TICK_MIN;
        else
            reload_period = TICK_BASE - step_total;
    end

    always_comb begin
        run_now    = (Game_status == 3'b010);
        entry      = run_now && (state != RUN);
        run_active = run_now && !paused;
        tick_now   = run_active && !entry && (counter == period - 32'd1);
        pop        = tick_now && (q_count != 2'd0);

        key_valid = Key_up | Key_down | Key_left | Key_right;
        if (Key_up)        cand = 2'b00;
        else if (Key_down) cand = 2'b01;
        else if (Key_left) cand = 2'b10;
        else               cand = 2'b11;

        // Reversal reference is always the pre-pop tail, or Dir when empty.
        case (q_count)
            2'd0:    ref_dir = Dir;
            2'd1:    ref_dir = q_slot0;
            default: ref_dir = q_slot1;
        endcase
        accept = run_active && key_valid && (cand != ref_dir) && (cand != (ref_dir ^ 2'b01));
    end

    always_ff @(posedge Clk_50mhz or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            Move_tick   <= 1'b0;
            Dir         <= 2'b11;
            Speed_level <= '0;
            Key_drop    <= 1'b0;
            counter     <= '0;
            period      <= TICK_BASE;
            q_slot0     <= '0;
            q_slot1     <= '0;
            q_count     <= '0;
        end else begin
            Move_tick <= 1'b0;
            Key_drop  <= 1'b0;
            case (Game_status)
                3'b001: begin
                    state       <= IDLE;
                    Dir         <= 2'b11;
                    Speed_level <= '0;
                    counter     <= '0;
                    q_count     <= '0;
                end
                3'b010: begin
                    state <= RUN;
                    if (entry) begin
                        counter <= '0;
                        period  <= reload_period;
                    end else if (!paused) begin
                        if (tick_now) begin
                            Move_tick <= 1'b1;
                            counter   <= '0;
                            period    <= reload_period;
                        end else begin
                            counter <= counter + 32'd1;
                        end
                    end

                    if (Body_add_sig && ({28'd0, Speed_level} < LVL_MAX))
                        Speed_level <= Speed_level + 4'd1;

                    if (pop)
                        Dir <= q_slot0;

                    case ({pop, accept})
                        2'b10: begin
                            q_slot0 <= q_slot1;
                            q_count <= q_count - 2'd1;
                        end
                        2'b01: begin
                            if (q_count == 2'd2) begin
                                Key_drop <= 1'b1;
                            end else begin
                                if (q_count == 2'd0)
                                    q_slot0 <= cand;
                                else
                                    q_slot1 <= cand;
                                q_count <= q_count + 2'd1;
                            end
                        end
                        2'b11: begin
                            if (q_count == 2'd2) begin
                                q_slot0 <= q_slot1;
                                q_slot1 <= cand;
                            end else begin
                                q_slot0 <= cand;
                            end
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state   <= HOLD;
                    counter <= '0;
                    q_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Directed bench for snake_move_scheduler with shortened tick parameters.
module tb_snake_move_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] game_status;
    logic       key_left, key_right, key_up, key_down;
    logic       body_add;
    logic       move_tick;
    logic [1:0] dir;
    logic [3:0] speed_level;
    logic       key_drop;
`ifdef PAUSE_EN
    logic       pause = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    snake_move_scheduler #(
        .TICK_BASE(20),
        .TICK_STEP(4),
        .TICK_MIN(8),
        .LVL_MAX(15)
    ) dut (
        .Clk_50mhz   (clk),
        .Rst         (rst),
        .Game_status (game_status),
        .Key_left    (key_left),
        .Key_right   (key_right),
        .Key_up      (key_up),
        .Key_down    (key_down),
        .Body_add_sig(body_add),
`ifdef PAUSE_EN
        .Pause       (pause),
`endif
        .Move_tick   (move_tick),
        .Dir         (dir),
        .Speed_level (speed_level),
        .Key_drop    (key_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // keys = {up, down, left, right}; returns Key_drop as seen after the edge
    task automatic press(input logic [3:0] keys, output logic drop);
        {key_up, key_down, key_left, key_right} = keys;
        step();
        {key_up, key_down, key_left, key_right} = 4'b0000;
        drop = key_drop;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!move_tick && n < 200);
    endtask

    task automatic body(input int k);
        for (int i = 0; i < k; i++) begin
            body_add = 1'b1;
            step();
        end
        body_add = 1'b0;
    endtask

    initial begin
        int   n;
        int   ticks;
        logic drop;

        rst = 1'b1;
        game_status = 3'b001;
        {key_up, key_down, key_left, key_right} = 4'b0000;
        body_add = 1'b0;
        step();
        step();
        check("rst_tick", move_tick, 0);
        check("rst_dir", dir, 3);
        check("rst_level", speed_level, 0);
        check("rst_drop", key_drop, 0);
        rst = 1'b0;
        step();

        // Basic pacing
        game_status = 3'b010;
        step();
        wait_tick(n);
        check("first_tick_cycles", n, 20);
        check("first_tick_dir", dir, 3);
        wait_tick(n);
        check("second_tick_cycles", n, 20);

        // Same and opposite of Dir are discarded
        press(4'b0010, drop);
        check("left_no_drop", drop, 0);
        press(4'b0001, drop);
        check("right_no_drop", drop, 0);
        wait_tick(n);
        check("t3_cycles", n, 18);
        check("t3_dir_a", dir, 3);
        wait_tick(n);
        check("t3_dir_b", dir, 3);

        // Up queued, down reverses the queued tail
        press(4'b1000, drop);
        check("up_no_drop", drop, 0);
        press(4'b0100, drop);
        check("down_no_drop", drop, 0);
        wait_tick(n);
        check("t2_cycles", n, 18);
        check("t2_dir", dir, 0);
        // down outranks left and is a reversal of up
        press(4'b0110, drop);
        wait_tick(n);
        check("prio_cycles", n, 19);
        check("prio_dir", dir, 0);

        // Full queue, drop, and pop+push on the tick edge
        game_status = 3'b001;
        step();
        check("idle_dir", dir, 3);
        game_status = 3'b010;
        step();
        press(4'b1000, drop);
        check("t4_up_drop", drop, 0);
        press(4'b0010, drop);
        check("t4_left_drop", drop, 0);
        press(4'b0100, drop);
        check("t4_full_drop", drop, 1);
        step();
        check("t4_drop_single", key_drop, 0);
        ticks = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            ticks += int'(move_tick);
        end
        check("t4_early_ticks", ticks, 0);
        key_down = 1'b1;
        step();
        key_down = 1'b0;
        check("t4_tick", move_tick, 1);
        check("t4_dir_up", dir, 0);
        check("t4_popfull_drop", key_drop, 0);
        wait_tick(n);
        check("t4_cycles", n, 20);
        check("t4_dir_left", dir, 2);
        wait_tick(n);
        check("t4_dir_down", dir, 1);

        // Speed levels affect only the following interval
        body(1);
        check("lvl1", speed_level, 1);
        wait_tick(n);
        check("lvl1_cur_interval", n, 19);
        wait_tick(n);
        check("lvl1_period", n, 16);
        body(2);
        check("lvl3", speed_level, 3);
        wait_tick(n);
        check("lvl3_cur_interval", n, 14);
        wait_tick(n);
        check("lvl3_period", n, 8);
        body(16);
        check("lvl_sat", speed_level, 15);
        wait_tick(n);
        wait_tick(n);
        check("lvl15_clamp", n, 8);

        // HOLD freezes Dir/level and flushes the queue
        press(4'b0010, drop);
        step();
        game_status = 3'b100;
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            ticks += int'(move_tick);
        end
        check("hold_no_tick", ticks, 0);
        check("hold_dir", dir, 1);
        check("hold_level", speed_level, 15);
        game_status = 3'b010;
        step();
        wait_tick(n);
        check("resume_cycles", n, 8);
        check("resume_flushed_dir", dir, 1);
        game_status = 3'b100;
        step();
        game_status = 3'b001;
        step();
        check("idle2_dir", dir, 3);
        check("idle2_level", speed_level, 0);
        game_status = 3'b010;
        step();
        wait_tick(n);
        check("rerun_cycles", n, 20);

        // Asynchronous reset mid-interval
        body(2);
        check("pre_rst_level", speed_level, 2);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_level", speed_level, 0);
        check("async_rst_dir", dir, 3);
        check("async_rst_tick", move_tick, 0);
        game_status = 3'b001;
        step();
        rst = 1'b0;
        step();
        game_status = 3'b010;
        step();
        wait_tick(n);
        check("post_rst_cycles", n, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_move_scheduler.md
Name: snake_move_scheduler

Overview:
Paces and sequences the snake datapath. Emits the single-cycle move strobe that advances the snake and arbitrates buffered direction-key requests into one committed direction per move. The move period shortens as apples are eaten. Sits between the key-check/game-control logic and the snake-motion logic, all in the 50 MHz domain.

Parameters:
TICK_BASE, 12500000, move period in clocks at speed level 0 (0.25 s)
TICK_STEP, 500000, period reduction per speed level
TICK_MIN, 2500000, lower clamp on the period
LVL_MAX, 15, saturation value of Speed_level

Ports:
Clk_50mhz  in  1  system clock, 50 MHz
Rst  in  1  asynchronous reset, active-high
Game_status  in  3  one-hot game state: 001 START, 010 PLAY, 100 END
Key_left  in  1  debounced one-cycle key pulse
Key_right  in  1  debounced one-cycle key pulse
Key_up  in  1  debounced one-cycle key pulse
Key_down  in  1  debounced one-cycle key pulse
Body_add_sig  in  1  one-cycle pulse, apple eaten
Move_tick  out  1  one-cycle move strobe
Dir  out  2  committed direction: 00 up, 01 down, 10 left, 11 right
Speed_level  out  4  current speed level
Key_drop  out  1  one-cycle pulse, valid key lost to a full queue

Behaviour:
- Reset values: Move_tick=0, Dir=11, Speed_level=0, Key_drop=0, queue empty, counter=0, period register=TICK_BASE, state IDLE.
- State machine, updated every cycle from Game_status:
  - 001 -> IDLE. Clears Dir to 11, level to 0, counter, and queue. No ticks.
  - 010 -> RUN.
  - 100 or any other code -> HOLD. Freezes Dir and level, flushes the queue, holds the counter at 0. No ticks.
- HOLD->RUN re-enters RUN with the frozen Dir and level. The period register reloads on entry to RUN.
- Key arbitration (RUN only):
  - At most one key is accepted per cycle; priority up > down > left > right.
  - The candidate is compared against the queue tail, or against Dir if the queue is empty.
  - A candidate equal to or opposite the reference is discarded silently.
- Queue: 2-entry FIFO.
  - Enqueue while full with no pop in the same cycle: the entry is discarded and Key_drop pulses in the next cycle.
- Period counter (RUN only):
  - Counts 0..P-1, where P is the period register.
  - When the counter reaches P-1: Move_tick=1 on the next cycle, counter returns to 0, and P reloads as max(TICK_BASE - Speed_level*TICK_STEP, TICK_MIN). The subtraction is 32-bit and clamped, never underflowing.
  - The first tick after entering RUN comes P cycles after entry.
- Pop on tick: if the queue is non-empty, the head moves to Dir in the same cycle Move_tick=1, so Dir is valid alongside Move_tick. If the queue is empty, Dir is unchanged.
- Simultaneous pop and enqueue:
  - Both take effect.
  - The reversal check uses the pre-pop tail (or the pre-pop Dir if the queue was empty).
  - A full queue that pops in the same cycle accepts the new entry with no Key_drop.
- Body_add_sig in RUN increments Speed_level, saturating at LVL_MAX. It affects only the next period reload, never the interval in progress. Ignored outside RUN.
- An asynchronous Rst mid-interval returns every output and all state to reset values immediately.

Optional Feature:
PAUSE_EN
- Defined:
  - Adds input Pause (one-cycle pulse). In RUN, each Pause pulse toggles a paused flag.
  - While paused: counter frozen, no Move_tick, keys ignored, queue contents retained, Body_add_sig still counted.
  - The paused flag clears on any exit from RUN and on Rst.
- Undefined: no Pause port and never paused.

Test Plan:
1. TICK_BASE=20, TICK_STEP=4, TICK_MIN=8; Rst, then Game_status=010 -> first Move_tick 20 cycles after entry, then every 20 cycles; Dir=11.
2. Key_up then Key_down before the next tick -> up queued, down discarded; next tick Dir=00; Key_drop stays 0.
3. Dir=11; Key_left, then Key_right -> both discarded; ticks keep Dir=11.
4. Key_up, Key_left, Key_down before a tick -> Key_drop pulses once on down; successive ticks give Dir=00, then Dir=10.
5. 3 Body_add_sig pulses -> Speed_level=3, period 8 from the following interval (interval in progress stays 20). 16 pulses -> Speed_level=15, period clamped at 8.
6. Game_status=100 mid-interval -> no Move_tick, Dir and level held. Then 001 -> Dir=11, Speed_level=0. Then 010 -> first tick after 20 cycles.
